// File: rtl/gpu_pkg.sv
// Shared GPU encodings: core_state broadcast values, LSU state values and the default PC width.
// Imported by the scheduler, ALUs, LSUs and decoder so every unit agrees on the encodings.
package gpu_pkg;

  localparam int PC_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } core_state_t;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_t;

endpackage

// File: rtl/sched_pc_select.sv
// Combinational pick of the lowest-indexed enabled thread's next_pc (current_pc+1 when none enabled).
// Optional SCHED_DIVERGENCE_CHECK_EN adds a flag raised when enabled threads disagree on next_pc.
module sched_pc_select
  import gpu_pkg::*;
#(
  parameter int THREADS = 4,
  parameter int PC_W    = PC_W_DEF
) (
  input  logic [THREADS-1:0]      thread_enable,
  input  logic [PC_W*THREADS-1:0] next_pc,
  input  logic [PC_W-1:0]         current_pc,
`ifdef SCHED_DIVERGENCE_CHECK_EN
  output logic                    diverge,
`endif
  output logic [PC_W-1:0]         sel_pc
);

  logic [PC_W-1:0] sel_pc_s;

  // Priority pick: walk from the top so the lowest enabled thread wins last
  always_comb begin
    sel_pc_s = current_pc + {{(PC_W-1){1'b0}}, 1'b1};
    for (int i = THREADS - 1; i >= 0; i--) begin
      sel_pc_s = thread_enable[i] ? next_pc[PC_W*i +: PC_W] : sel_pc_s;
    end
  end

  assign sel_pc = sel_pc_s;

`ifdef SCHED_DIVERGENCE_CHECK_EN
  logic diverge_s;

  // Any enabled thread differing from the winner implies two enabled threads differ
  always_comb begin
    diverge_s = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      diverge_s = diverge_s | (thread_enable[i] & (next_pc[PC_W*i +: PC_W] != sel_pc_s));
    end
  end

  assign diverge = diverge_s;
`endif

endmodule

// File: rtl/core_scheduler.sv
// Per-core FSM sequencing FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE and owning the core PC.
// Optional macro SCHED_DIVERGENCE_CHECK_EN adds the sticky divergence_err output.
module core_scheduler
  import gpu_pkg::*;
#(
  parameter int THREADS = 4,
  parameter int PC_W    = PC_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [THREADS-1:0]        thread_enable,
  output logic                      fetch_req,
  input  logic                      fetch_ready,
  input  logic                      decoded_mem_read_enable,
  input  logic                      decoded_mem_write_enable,
  input  logic                      decoded_ret,
  input  logic [2*THREADS-1:0]      lsu_state,
  input  logic [PC_W*THREADS-1:0]   next_pc,
`ifdef SCHED_DIVERGENCE_CHECK_EN
  output logic                      divergence_err,
`endif
  output logic [2:0]                core_state,
  output logic [PC_W-1:0]           current_pc,
  output logic                      done
);

  core_state_t     state_r;
  core_state_t     state_nxt_s;
  logic            fetch_req_r;
  logic            done_r;
  logic [PC_W-1:0] current_pc_r;
  logic [PC_W-1:0] sel_pc_s;
  logic            wait_done_s;
  logic            mem_instr_s;

  assign mem_instr_s = decoded_mem_read_enable | decoded_mem_write_enable;

  // Every enabled thread must report LSU_DONE; disabled threads never block
  always_comb begin
    wait_done_s = 1'b1;
    for (int i = 0; i < THREADS; i++) begin
      wait_done_s = wait_done_s &
                    (~thread_enable[i] | (lsu_state[2*i +: 2] == LSU_DONE));
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:    state_nxt_s = start ? S_FETCH : S_IDLE;
      S_FETCH:   state_nxt_s = fetch_ready ? S_DECODE : S_FETCH;
      S_DECODE:  state_nxt_s = S_REQUEST;
      S_REQUEST: state_nxt_s = S_WAIT;
      S_WAIT:    state_nxt_s = (~mem_instr_s | wait_done_s) ? S_EXECUTE : S_WAIT;
      S_EXECUTE: state_nxt_s = S_UPDATE;
      S_UPDATE:  state_nxt_s = decoded_ret ? S_DONE : S_FETCH;
      S_DONE:    state_nxt_s = S_DONE;
      default:   state_nxt_s = S_IDLE;
    endcase
  end

  // State, PC and registered outputs; outputs follow the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      current_pc_r <= {PC_W{1'b0}};
      fetch_req_r  <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      fetch_req_r <= (state_nxt_s == S_FETCH);
      done_r      <= (state_nxt_s == S_DONE);
      if ((state_r == S_UPDATE) && !decoded_ret) begin
        current_pc_r <= sel_pc_s;
      end else begin
        current_pc_r <= current_pc_r;
      end
    end
  end

`ifdef SCHED_DIVERGENCE_CHECK_EN
  logic diverge_s;
  logic divergence_err_r;

  // Sticky divergence flag, sampled only on non-RET updates
  always_ff @(posedge clk) begin
    if (reset) begin
      divergence_err_r <= 1'b0;
    end else if ((state_r == S_UPDATE) && !decoded_ret && diverge_s) begin
      divergence_err_r <= 1'b1;
    end else begin
      divergence_err_r <= divergence_err_r;
    end
  end

  assign divergence_err = divergence_err_r;
`endif

  sched_pc_select #(
    .THREADS (THREADS),
    .PC_W    (PC_W)
  ) u_pc_select (
    .thread_enable (thread_enable),
    .next_pc       (next_pc),
    .current_pc    (current_pc_r),
`ifdef SCHED_DIVERGENCE_CHECK_EN
    .diverge       (diverge_s),
`endif
    .sel_pc        (sel_pc_s)
  );

  assign core_state = state_r;
  assign current_pc = current_pc_r;
  assign fetch_req  = fetch_req_r;
  assign done       = done_r;

endmodule

// File: tb/tb_core_scheduler.sv
// Scoreboard bench for core_scheduler: per-cycle expectations are queued as stimulus is driven
// and compared at the following falling edge.
module tb_core_scheduler;

  localparam int THREADS = 4;
  localparam int PC_W    = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    start;
  logic [THREADS-1:0]      thread_enable;
  logic                    fetch_req;
  logic                    fetch_ready;
  logic                    decoded_mem_read_enable;
  logic                    decoded_mem_write_enable;
  logic                    decoded_ret;
  logic [2*THREADS-1:0]    lsu_state;
  logic [PC_W*THREADS-1:0] next_pc;
  logic [2:0]              core_state;
  logic [PC_W-1:0]         current_pc;
  logic                    done;
`ifdef SCHED_DIVERGENCE_CHECK_EN
  logic                    divergence_err;
`endif

  core_scheduler #(.THREADS(THREADS), .PC_W(PC_W)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .start                    (start),
    .thread_enable            (thread_enable),
    .fetch_req                (fetch_req),
    .fetch_ready              (fetch_ready),
    .decoded_mem_read_enable  (decoded_mem_read_enable),
    .decoded_mem_write_enable (decoded_mem_write_enable),
    .decoded_ret              (decoded_ret),
    .lsu_state                (lsu_state),
    .next_pc                  (next_pc),
`ifdef SCHED_DIVERGENCE_CHECK_EN
    .divergence_err           (divergence_err),
`endif
    .core_state               (core_state),
    .current_pc               (current_pc),
    .done                     (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] pc;
    logic       fr;
    logic       dn;
    logic       dv;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  logic  exp_div;
  int    errors = 0;
  int    checks = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t  e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_val({t, ".state"}, 32'(core_state), 32'(e.st));
      check_val({t, ".pc"},    32'(current_pc), 32'(e.pc));
      check_val({t, ".freq"},  32'(fetch_req),  32'(e.fr));
      check_val({t, ".done"},  32'(done),       32'(e.dn));
`ifdef SCHED_DIVERGENCE_CHECK_EN
      check_val({t, ".div"},   32'(divergence_err), 32'(e.dv));
`endif
    end
  end

  // Queue the outputs expected after the next rising edge, then advance one cycle
  task automatic tick(input string tag, input logic [2:0] st, input logic [7:0] pc,
                      input logic fr, input logic dn);
    exp_t e;
    e.st = st; e.pc = pc; e.fr = fr; e.dn = dn; e.dv = exp_div;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  function automatic logic diverges(input logic [3:0] en, input logic [31:0] npc);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (en[i] && en[j] && (npc[8*i +: 8] != npc[8*j +: 8])) return 1'b1;
    return 1'b0;
  endfunction

  // One instruction starting in FETCH. dN: WAIT cycle at which thread N shows 11 (-1 = held at 01).
  // abort_w >= 0 asserts reset in that WAIT cycle and returns.
  task automatic do_instr(input string nm, input logic [7:0] pc, input int fr_delay,
                          input logic rd, input logic wr, input logic ret,
                          input logic [3:0] en, input logic [31:0] npc,
                          input int d0, input int d1, input int d2, input int d3,
                          input int abort_w, input logic [7:0] exp_next);
    int dn_at[4];
    dn_at[0] = d0; dn_at[1] = d1; dn_at[2] = d2; dn_at[3] = d3;
    thread_enable = en;
    next_pc       = npc;
    for (int k = 0; k < fr_delay; k++) begin
      fetch_ready = 1'b0;
      tick({nm, ".fetch"}, 3'b001, pc, 1'b1, 1'b0);
    end
    fetch_ready = 1'b1;
    tick({nm, ".decode"}, 3'b010, pc, 1'b0, 1'b0);
    fetch_ready = 1'b0;
    decoded_mem_read_enable  = rd;
    decoded_mem_write_enable = wr;
    decoded_ret              = ret;
    tick({nm, ".request"}, 3'b011, pc, 1'b0, 1'b0);
    tick({nm, ".wait0"},   3'b100, pc, 1'b0, 1'b0);
    for (int w = 0; w < 40; w++) begin
      logic all_done;
      all_done = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (!(rd || wr))                        lsu_state[2*i +: 2] = 2'b00;
        else if (dn_at[i] < 0)                  lsu_state[2*i +: 2] = 2'b01;
        else if (w >= dn_at[i])                 lsu_state[2*i +: 2] = 2'b11;
        else if (w < 1)                         lsu_state[2*i +: 2] = 2'b01;
        else                                    lsu_state[2*i +: 2] = 2'b10;
        if (en[i] && (lsu_state[2*i +: 2] != 2'b11)) all_done = 1'b0;
      end
      if (!(rd || wr)) all_done = 1'b1;
      if (w == abort_w) begin
        reset   = 1'b1;
        exp_div = 1'b0;
        tick({nm, ".reset_in_wait"}, 3'b000, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        lsu_state = '0;
        decoded_mem_read_enable = 1'b0; decoded_mem_write_enable = 1'b0; decoded_ret = 1'b0;
        return;
      end
      if (all_done) begin
        tick({nm, ".execute"}, 3'b101, pc, 1'b0, 1'b0);
        break;
      end else begin
        tick({nm, ".wait"}, 3'b100, pc, 1'b0, 1'b0);
      end
    end
    lsu_state = '0;
    tick({nm, ".update"}, 3'b110, pc, 1'b0, 1'b0);
    if (ret) begin
      tick({nm, ".done"}, 3'b111, pc, 1'b0, 1'b1);
    end else begin
      if (diverges(en, npc)) exp_div = 1'b1;
      tick({nm, ".next"}, 3'b001, exp_next, 1'b1, 1'b0);
    end
    decoded_mem_read_enable = 1'b0; decoded_mem_write_enable = 1'b0; decoded_ret = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; thread_enable = '0; fetch_ready = 1'b0;
    decoded_mem_read_enable = 1'b0; decoded_mem_write_enable = 1'b0; decoded_ret = 1'b0;
    lsu_state = '0; next_pc = '0; exp_div = 1'b0;

    tick("rst0", 3'b000, 8'h00, 1'b0, 1'b0);
    tick("rst1", 3'b000, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    tick("idle_hold", 3'b000, 8'h00, 1'b0, 1'b0);

    // Basic non-memory instruction, fetch_ready one cycle after fetch_req
    start = 1'b1;
    tick("start", 3'b001, 8'h00, 1'b1, 1'b0);
    start = 1'b0;
    do_instr("nop", 8'h00, 1, 1'b0, 1'b0, 1'b0, 4'b1111, {4{8'h01}},
             0, 0, 0, 0, -1, 8'h01);

    // LDR, thread 3 disabled and stuck at REQUESTING
    do_instr("ldr", 8'h01, 2, 1'b1, 1'b0, 1'b0, 4'b0111, {8'h77, 8'h02, 8'h02, 8'h02},
             3, 5, 7, -1, -1, 8'h02);

    do_instr("to5", 8'h02, 0, 1'b0, 1'b0, 1'b0, 4'b1111, {4{8'h05}},
             0, 0, 0, 0, -1, 8'h05);
    do_instr("ret", 8'h05, 0, 1'b0, 1'b0, 1'b1, 4'b1111, {4{8'h09}},
             0, 0, 0, 0, -1, 8'h00);
    for (int k = 0; k < 20; k++) begin
      start       = k[0];
      fetch_ready = ~k[0];
      tick("done_hold", 3'b111, 8'h05, 1'b0, 1'b1);
    end
    start = 1'b0; fetch_ready = 1'b0;

    // Reset from DONE, move the PC, then reset in the middle of an STR wait
    reset = 1'b1; exp_div = 1'b0;
    tick("rst_done", 3'b000, 8'h00, 1'b0, 1'b0);
    reset = 1'b0; start = 1'b1;
    tick("start2", 3'b001, 8'h00, 1'b1, 1'b0);
    start = 1'b0;
    do_instr("pre", 8'h00, 0, 1'b0, 1'b0, 1'b0, 4'b1111, {4{8'h33}},
             0, 0, 0, 0, -1, 8'h33);
    do_instr("str", 8'h33, 1, 1'b0, 1'b1, 1'b0, 4'b1111, {4{8'h34}},
             10, 10, 10, 10, 2, 8'h00);
    tick("idle_after_rst", 3'b000, 8'h00, 1'b0, 1'b0);

    // Divergent PCs among enabled threads 2 and 3
    start = 1'b1;
    tick("start3", 3'b001, 8'h00, 1'b1, 1'b0);
    start = 1'b0;
    do_instr("div", 8'h00, 0, 1'b0, 1'b0, 1'b0, 4'b1100, {8'h20, 8'h10, 8'hBB, 8'hAA},
             0, 0, 0, 0, -1, 8'h10);
    do_instr("same", 8'h10, 0, 1'b0, 1'b0, 1'b0, 4'b1111, {4{8'h11}},
             0, 0, 0, 0, -1, 8'h11);

    // PC wrap with no enabled threads; memory wait is vacuously satisfied
    do_instr("toFF", 8'h11, 0, 1'b0, 1'b0, 1'b0, 4'b1111, {4{8'hFF}},
             0, 0, 0, 0, -1, 8'hFF);
    do_instr("wrap", 8'hFF, 0, 1'b1, 1'b0, 1'b0, 4'b0000, {4{8'h42}},
             -1, -1, -1, -1, -1, 8'h00);

    @(negedge clk);
    #1;
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
